// File: rtl/uart_pkg.sv
// Shared UART definitions: word-length encodings, TX state machine states and
// the default minimum divisor.
package uart_pkg;

  localparam int unsigned MIN_DIV = 2;

  typedef enum logic [1:0] {
    WLEN_5 = 2'b00,
    WLEN_6 = 2'b01,
    WLEN_7 = 2'b10,
    WLEN_8 = 2'b11
  } wlen_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// Baud counter: counts 0..limit-1 and strobes bit_end on the last count.
// Wraps on bit_end and is held at zero while clear is asserted.
module uart_baud_gen #(
  parameter int unsigned W = 17
) (
  input  logic         i_sys_clk,
  input  logic         i_sys_rst_n,
  input  logic         clear,
  input  logic [W-1:0] limit,
  output logic         bit_end
);

  logic [W-1:0] count;

  assign bit_end = (count == limit - W'(1));

  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      count <= '0;
    end else if (clear || bit_end) begin
      count <= '0;
    end else begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter: 5-8 data bits, none/odd/even/stick
// parity, 1/1.5/2 stop bits, programmable divisor and line break.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned DIV_W   = 16,
  parameter int unsigned MIN_DIV = uart_pkg::MIN_DIV
) (
  input  logic             i_sys_clk,
  input  logic             i_sys_rst_n,
  input  logic [7:0]       i_data,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [DIV_W-1:0] i_divisor,
  input  logic [1:0]       i_wlen,
  input  logic             i_stop2,
  input  logic             i_par_en,
  input  logic             i_par_even,
  input  logic             i_par_stick,
  input  logic             i_break,
  output logic             o_tx,
  output logic             o_busy,
  output logic             o_done
);

  tx_state_e        state;
  logic [7:0]       sh;
  logic [2:0]       bit_cnt;
  logic [2:0]       last_bit;
  logic             par_acc;
  wlen_e            wlen_q;
  logic             par_en_q, par_even_q, stick_q;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W:0]   stop_q;
  logic [DIV_W-1:0] div_in;
  logic [DIV_W:0]   div_in_x, stop_in, limit;
  logic             bit_end, tx_q, done_q, accept, par_data, par_bit;

  assign div_in   = (i_divisor < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : i_divisor;
  assign div_in_x = {1'b0, div_in};
  // The whole stop period is one baud-counter interval with its own limit.
  assign stop_in  = (i_stop2 && (i_wlen == WLEN_5)) ? div_in_x + (div_in_x >> 1)
                  : i_stop2                         ? (div_in_x << 1)
                  :                                   div_in_x;

  assign limit    = (state == ST_STOP) ? stop_q : {1'b0, div_q};
  assign last_bit = 3'd4 + 3'(wlen_q);
  assign par_data = par_acc ^ sh[0];
  assign par_bit  = stick_q ? ~par_even_q : (par_even_q ? par_data : ~par_data);

  assign o_ready  = (state == ST_IDLE) || ((state == ST_STOP) && bit_end);
  assign accept   = i_valid && o_ready;

  uart_baud_gen #(.W(DIV_W + 1)) u_baud (
    .i_sys_clk  (i_sys_clk),
    .i_sys_rst_n(i_sys_rst_n),
    .clear      (state == ST_IDLE),
    .limit      (limit),
    .bit_end    (bit_end)
  );

  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      state      <= ST_IDLE;
      sh         <= '0;
      bit_cnt    <= '0;
      par_acc    <= 1'b0;
      wlen_q     <= WLEN_5;
      par_en_q   <= 1'b0;
      par_even_q <= 1'b0;
      stick_q    <= 1'b0;
      div_q      <= '0;
      stop_q     <= '0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      done_q <= (state == ST_STOP) && bit_end;
      if (accept) begin
        state      <= ST_START;
        sh         <= i_data;
        bit_cnt    <= '0;
        par_acc    <= 1'b0;
        wlen_q     <= wlen_e'(i_wlen);
        par_en_q   <= i_par_en;
        par_even_q <= i_par_even;
        stick_q    <= i_par_stick;
        div_q      <= div_in;
        stop_q     <= stop_in;
        tx_q       <= 1'b0;
      end else if (bit_end) begin
        case (state)
          ST_START: begin
            state <= ST_DATA;
            tx_q  <= sh[0];
          end
          ST_DATA: begin
            par_acc <= par_data;
            sh      <= sh >> 1;
            if (bit_cnt == last_bit) begin
              state <= par_en_q ? ST_PARITY : ST_STOP;
              tx_q  <= par_en_q ? par_bit : 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              tx_q    <= sh[1];
            end
          end
          ST_PARITY: begin
            state <= ST_STOP;
            tx_q  <= 1'b1;
          end
          ST_STOP: begin
            state <= ST_IDLE;
            tx_q  <= 1'b1;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign o_tx   = tx_q & ~i_break;
  assign o_busy = (state != ST_IDLE);
  assign o_done = done_q;

endmodule
